// File: rtl/shadow_reg_restore_unit.sv
// Pops the top {mepc, mcause} shadow frame over a dedicated dcache load port on mret.
// Optional macro SHRU_RESTORE_UNDERFLOW_EN adds underflow_o for empty pops and full pushes.
module shadow_reg_restore_unit #(
   parameter int unsigned     XLEN               = 64,
   parameter int unsigned     DCACHE_INDEX_WIDTH = 12,
   parameter int unsigned     DCACHE_TAG_WIDTH   = 44,
   parameter int unsigned     STACK_DEPTH        = 8,
   parameter logic [XLEN-1:0] STACK_BASE         = {XLEN{1'b0}}
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          push_i,
   input  logic                          restore_req_i,
   input  logic                          store_pending_i,
   output logic                          restore_valid_o,
   output logic [XLEN-1:0]               restore_mepc_o,
   output logic [XLEN-1:0]               restore_mcause_o,
   output logic [$clog2(STACK_DEPTH):0]  depth_o,
   output logic                          busy_o,
   output logic [DCACHE_INDEX_WIDTH-1:0] address_index_o,
   output logic [DCACHE_TAG_WIDTH-1:0]   address_tag_o,
   output logic                          data_req_o,
   input  logic                          data_gnt_i,
   output logic                          tag_valid_o,
   output logic                          kill_req_o,
   input  logic                          data_rvalid_i,
   input  logic [XLEN-1:0]               data_rdata_i
`ifdef SHRU_RESTORE_UNDERFLOW_EN
   ,
   output logic                          underflow_o
`endif
);
   localparam int unsigned DW          = $clog2(STACK_DEPTH) + 1;
   localparam int unsigned FRAME_BYTES = 2 * XLEN / 8;
   localparam int unsigned WORD_BYTES  = XLEN / 8;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_REQ_EPC  = 3'd1;
   localparam logic [2:0] S_TAG_EPC  = 3'd2;
   localparam logic [2:0] S_WAIT_EPC = 3'd3;
   localparam logic [2:0] S_REQ_CAU  = 3'd4;
   localparam logic [2:0] S_TAG_CAU  = 3'd5;
   localparam logic [2:0] S_WAIT_CAU = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [DW-1:0]   r_depth;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_epc_buf;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic            r_empty;
   logic            r_kill;
   logic            w_full;
   logic            w_dec;
   logic            w_start;
   logic            w_in_epc;
   logic            w_in_cau;
   logic            w_cap;
   logic            w_kill;
   logic [XLEN-1:0] w_top_addr;

   assign w_full     = (r_depth == DW'(STACK_DEPTH));
   assign w_dec      = (r_state == S_DONE) && !r_empty;
   assign w_start    = (r_state == S_IDLE) && (w_next != S_IDLE);
   assign w_in_epc   = (r_state == S_TAG_EPC) || (r_state == S_WAIT_EPC);
   assign w_in_cau   = (r_state == S_TAG_CAU) || (r_state == S_WAIT_CAU);
   assign w_cap      = data_rvalid_i && !flush_i;
   assign w_kill     = flush_i && (w_in_epc || w_in_cau);
   assign w_top_addr = STACK_BASE + ((XLEN'(r_depth) - XLEN'(1)) * XLEN'(FRAME_BYTES));

   // Next-state: rvalid may already arrive in the TAG cycle, which skips the WAIT state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (restore_req_i && !store_pending_i && !flush_i) begin
               if (r_depth == {DW{1'b0}}) w_next = S_DONE;
               else                       w_next = S_REQ_EPC;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_REQ_EPC: begin
            if (flush_i)         w_next = S_IDLE;
            else if (data_gnt_i) w_next = S_TAG_EPC;
            else                 w_next = S_REQ_EPC;
         end
         S_TAG_EPC, S_WAIT_EPC: begin
            if (flush_i)            w_next = S_IDLE;
            else if (data_rvalid_i) w_next = S_REQ_CAU;
            else                    w_next = S_WAIT_EPC;
         end
         S_REQ_CAU: begin
            if (flush_i)         w_next = S_IDLE;
            else if (data_gnt_i) w_next = S_TAG_CAU;
            else                 w_next = S_REQ_CAU;
         end
         S_TAG_CAU, S_WAIT_CAU: begin
            if (flush_i)            w_next = S_IDLE;
            else if (data_rvalid_i) w_next = S_DONE;
            else                    w_next = S_WAIT_CAU;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State, frame address and captured data; outputs change together only on completion.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_addr    <= {XLEN{1'b0}};
         r_epc_buf <= {XLEN{1'b0}};
         r_mepc    <= {XLEN{1'b0}};
         r_mcause  <= {XLEN{1'b0}};
         r_empty   <= 1'b0;
         r_kill    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_kill  <= w_kill;
         if (w_start) begin
            r_addr  <= w_top_addr;
            r_empty <= (r_depth == {DW{1'b0}});
`ifndef SHRU_RESTORE_UNDERFLOW_EN
            if (r_depth == {DW{1'b0}}) begin
               r_mepc   <= {XLEN{1'b0}};
               r_mcause <= {XLEN{1'b0}};
            end
`endif
         end else if (w_in_epc && w_cap) begin
            r_epc_buf <= data_rdata_i;
            r_addr    <= r_addr + XLEN'(WORD_BYTES);
         end else if (w_in_cau && w_cap) begin
            r_mepc   <= r_epc_buf;
            r_mcause <= data_rdata_i;
         end
      end
   end

   // Depth: saturating push, pop on completion, simultaneous push and pop cancel.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_depth <= {DW{1'b0}};
      end else begin
         case ({push_i, w_dec})
            2'b10: begin
               if (!w_full) r_depth <= r_depth + DW'(1);
            end
            2'b01:   r_depth <= r_depth - DW'(1);
            default: r_depth <= r_depth;
         endcase
      end
   end

`ifdef SHRU_RESTORE_UNDERFLOW_EN
   logic r_underflow;

   // Underflow pulse: empty pop request or push with no room left.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= (w_start && (r_depth == {DW{1'b0}})) || (push_i && w_full && !w_dec);
      end
   end

   assign underflow_o     = r_underflow;
   assign restore_valid_o = (r_state == S_DONE) && !r_empty;
`else
   assign restore_valid_o = (r_state == S_DONE);
`endif

   assign restore_mepc_o   = r_mepc;
   assign restore_mcause_o = r_mcause;
   assign depth_o          = r_depth;
   assign busy_o           = (r_state != S_IDLE);
   assign data_req_o       = (r_state == S_REQ_EPC) || (r_state == S_REQ_CAU);
   assign tag_valid_o      = (r_state == S_TAG_EPC) || (r_state == S_TAG_CAU);
   assign kill_req_o       = r_kill;
   assign address_index_o  = data_req_o ? r_addr[DCACHE_INDEX_WIDTH-1:0] : {DCACHE_INDEX_WIDTH{1'b0}};
   assign address_tag_o    = tag_valid_o ? r_addr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH]
                                         : {DCACHE_TAG_WIDTH{1'b0}};
endmodule

// File: doc/shadow_reg_restore_unit.md
Name: shadow_reg_restore_unit

Overview:
- Read-side counterpart of the shadow register store unit (ShRU).
- ShRU pushes {mepc, mcause} frames to a memory-backed shadow stack on nested traps. This block pops the top frame on mret through a dcache load port and hands the values to the CSR regfile.
- Sits beside the load unit on a dedicated dcache request port.

Parameters:
- XLEN, 64, register width; frame = 2*XLEN/8 bytes.
- DCACHE_INDEX_WIDTH, 12, width of the dcache address index.
- DCACHE_TAG_WIDTH, 44, width of the dcache address tag.
- STACK_DEPTH, 8, maximum frames tracked; power of two.
- STACK_BASE, 64'h0, physical byte address of frame 0; frame-aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- flush_i  in  1  abort in-flight restore
- push_i  in  1  ShRU committed one frame store (pulse)
- restore_req_i  in  1  mret needs shadow frame; held until restore_valid_o
- store_pending_i  in  1  ShRU has an uncommitted store
- restore_valid_o  out  1  restored values valid (1-cycle pulse)
- restore_mepc_o  out  XLEN  restored mepc
- restore_mcause_o  out  XLEN  restored mcause
- depth_o  out  $clog2(STACK_DEPTH)+1  frames currently held
- busy_o  out  1  FSM not IDLE
- address_index_o  out  DCACHE_INDEX_WIDTH  dcache index
- address_tag_o  out  DCACHE_TAG_WIDTH  dcache tag
- data_req_o  out  1  dcache request
- data_gnt_i  in  1  dcache grant
- tag_valid_o  out  1  tag valid
- kill_req_o  out  1  kill outstanding request
- data_rvalid_i  in  1  read data valid
- data_rdata_i  in  XLEN  read data

Behaviour:
- Reset: all outputs 0; depth 0; FSM IDLE. Reset mid-restore discards the transaction with no kill.
- Depth counter:
  - push_i increments; saturates at STACK_DEPTH, no wrap.
  - A completed restore decrements.
  - push_i and a decrement in the same cycle leave depth unchanged.
- Address for the top frame (top = depth-1):
  - mepc at STACK_BASE + top*2*XLEN/8.
  - mcause at mepc address + XLEN/8.
  - index = addr[DCACHE_INDEX_WIDTH-1:0]; tag = addr[DCACHE_INDEX_WIDTH+:DCACHE_TAG_WIDTH].
- FSM states: IDLE, REQ_EPC, TAG_EPC, WAIT_EPC, REQ_CAU, TAG_CAU, WAIT_CAU, DONE.
  - IDLE -> REQ_EPC when restore_req_i & !store_pending_i & depth!=0. Frame address latched on entry.
  - REQ_*: data_req_o=1, index driven; on data_gnt_i -> TAG_*.
  - TAG_*: tag_valid_o=1, tag driven, exactly one cycle after grant -> WAIT_*.
  - WAIT_*: on data_rvalid_i, capture data. rvalid may arrive in the TAG cycle; that data is captured and the state skips to the next REQ/DONE. WAIT_EPC -> REQ_CAU; WAIT_CAU -> DONE.
  - DONE: restore_valid_o=1 one cycle, depth decremented -> IDLE.
- Minimum latency: restore_req_i to restore_valid_o = 7 cycles (grant and rvalid each one cycle after request/tag).
- Output registers: restore_mepc_o and restore_mcause_o are registered and hold their last value until the next restore.
- Empty stack: restore_req_i with depth 0 gives restore_valid_o on the next cycle, both values 0, depth stays 0, no dcache access.
- Flush:
  - In REQ_*: deassert req -> IDLE.
  - In TAG_* or WAIT_*: kill_req_o=1 for one cycle, later rvalid ignored -> IDLE.
  - Depth unchanged by any flush.
- Ordering: a push_i arriving while busy does not change the latched address.

Optional Feature:
- Macro SHRU_RESTORE_UNDERFLOW_EN.
- Defined:
  - Adds output underflow_o (1 bit, reset 0).
  - Restore with depth 0 pulses underflow_o instead of restore_valid_o; values unchanged.
  - Push at full depth also pulses underflow_o.
- Undefined: port absent; empty-stack behaviour as in Behaviour.

Test Plan:
- 2 pushes, restore_req_i; dcache returns 0x8000_1000 then 0x8 -> loads at STACK_BASE+0x10 and +0x18; restore_valid_o after 7 cycles; mepc 0x8000_1000, mcause 0x8; depth_o 2->1.
- restore_req_i with store_pending_i=1 for 3 cycles -> no data_req_o until pending drops, then normal restore.
- flush_i in WAIT_EPC -> kill_req_o pulse, late rvalid ignored, IDLE, depth_o unchanged.
- depth 0 restore -> restore_valid_o next cycle, values 0, no data_req_o; with the macro, underflow_o=1 instead.
- push_i in the DONE cycle at depth 3 -> depth_o stays 3.
- 9 pushes with STACK_DEPTH 8 -> depth_o saturates at 8; with the macro, underflow_o pulses on the 9th.
